// File: rtl/spiking_systolic_ctrl.sv
// ---------------------------------------------------------------------------
// spiking_systolic_ctrl
//
// Sequencer for an N x N spiking systolic array. It takes a job length and a
// stream of spike/weight vectors from the host and writes them into the
// per-row and per-column operand FIFOs. It then clears the PE accumulators,
// issues diagonally skewed FIFO read enables, waits for the array to drain
// and pulses done.
//
// Ports
//   clk, rstn            clock, synchronous active-low reset
//   start, len           job request and length (1..DEPTH), sampled in IDLE
//   abort                synchronous job cancel
//   in_valid, in_ready   host vector handshake
//   in_spikes            one spike bit per row (bit i -> row FIFO i)
//   in_weights           one DATA_WIDTH slice per column (slice j -> col FIFO j)
//   row_w_en, col_w_en   FIFO write enables (one per row / column)
//   row_r_en, col_r_en   skewed FIFO read enables
//   row_wdata, col_wdata combinational pass-through of in_spikes / in_weights
//   pe_rstn              active-low PE accumulator clear
//   busy                 high outside IDLE
//   done                 one-cycle pulse when results are valid
//   err                  one-cycle pulse when start carries an illegal len
// ---------------------------------------------------------------------------
module spiking_systolic_ctrl #(
    parameter int unsigned N          = 3,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LEN_W      = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len,
    input  logic                    abort,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N-1:0]            in_spikes,
    input  logic [N*DATA_WIDTH-1:0] in_weights,
    output logic [N-1:0]            row_w_en,
    output logic [N-1:0]            row_r_en,
    output logic [N-1:0]            col_w_en,
    output logic [N-1:0]            col_r_en,
    output logic [N-1:0]            row_wdata,
    output logic [N*DATA_WIDTH-1:0] col_wdata,
    output logic                    pe_rstn,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    // One counter serves as LOAD beat count, STREAM step and DRAIN count.
    // Largest value held is max(DEPTH, DEPTH+N-2, N-1) < DEPTH+N.
    localparam int unsigned CW = $clog2(DEPTH + N + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [N-1:0]      r_en_q, r_en_d;
    logic              pe_rstn_q, pe_rstn_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              abort_hit;
    logic              len_ok;
    logic              w_fire;

    assign len_ok = (len != '0) && (32'(len) <= DEPTH);

    // Next-state logic. Registered outputs are derived from the next state so
    // that they line up with the state they describe.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        err_d     = 1'b0;
        abort_hit = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (len_ok) begin
                        len_d   = len;
                        cnt_d   = '0;
                        state_d = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    cnt_d = cnt_q + CW'(1);
                    if (32'(cnt_q) + 32'd1 == 32'(len_q)) begin
                        state_d = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                cnt_d   = '0;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                // Last step is len+N-2: the final operand enters row/col N-1.
                if (32'(cnt_q) == 32'(len_q) + N - 2) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DRAIN: begin
                if (32'(cnt_q) == N - 1) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            abort_hit = 1'b1;
            cnt_d     = '0;
            state_d   = S_IDLE;
        end

        // Diagonal skew: lane i is active for len steps starting at step i.
        r_en_d = '0;
        if (state_d == S_STREAM) begin
            for (int unsigned i = 0; i < N; i++) begin
                r_en_d[i] = (32'(cnt_d) >= i) && (32'(cnt_d) < i + 32'(len_q));
            end
        end

        pe_rstn_d = !((state_d == S_CLEAR) || abort_hit);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            r_en_q    <= '0;
            pe_rstn_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            r_en_q    <= r_en_d;
            pe_rstn_q <= pe_rstn_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Write enables must coincide with the host handshake because the write
    // data is a pass-through, so they decode the state register with in_valid.
    assign in_ready  = (state_q == S_LOAD);
    assign w_fire    = in_ready && in_valid;
    assign row_w_en  = {N{w_fire}};
    assign col_w_en  = {N{w_fire}};
    assign row_wdata = in_spikes;
    assign col_wdata = in_weights;

    assign row_r_en  = r_en_q;
    assign col_r_en  = r_en_q;
    assign pe_rstn   = pe_rstn_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_spiking_systolic_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for spiking_systolic_ctrl. The reference model tracks a job as a
// handful of integers (accepted length, handshake count, current cycle and the
// cycle of the last handshake) and derives every expected output from the
// job milestones with plain arithmetic. Per-row / per-column occupancy
// counters stand in for the FIFOs and flag any overflow or underflow.
// ---------------------------------------------------------------------------
module tb_spiking_systolic_ctrl;

    localparam int N     = 3;
    localparam int DEPTH = 8;
    localparam int DW    = 16;
    localparam int LW    = 4;

    logic            clk;
    logic            rstn;
    logic            start;
    logic [LW-1:0]   len;
    logic            abort;
    logic            in_valid;
    logic            in_ready;
    logic [N-1:0]    in_spikes;
    logic [N*DW-1:0] in_weights;
    logic [N-1:0]    row_w_en, row_r_en, col_w_en, col_r_en;
    logic [N-1:0]    row_wdata;
    logic [N*DW-1:0] col_wdata;
    logic            pe_rstn, busy, done, err;

    spiking_systolic_ctrl #(
        .N(N), .DEPTH(DEPTH), .DATA_WIDTH(DW), .LEN_W(LW)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .len(len), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_spikes(in_spikes), .in_weights(in_weights),
        .row_w_en(row_w_en), .row_r_en(row_r_en),
        .col_w_en(col_w_en), .col_r_en(col_r_en),
        .row_wdata(row_wdata), .col_wdata(col_wdata),
        .pe_rstn(pe_rstn), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    bit m_active = 0, m_load = 0, m_err = 0, m_abort = 0, m_inreset = 1;
    int m_L = 0, m_hs = 0, m_c = 0, m_lend = 0;
    int rel_cyc = 0;

    // Observation counters.
    int done_cnt = 0, done_cyc = -1, err_cnt = 0, wr_cnt = 0;
    int flow_err = 0;
    int rocc[N];
    int cocc[N];
    bit chk_en = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    task automatic model_update();
        m_err   = 0;
        m_abort = 0;
        rel_cyc++;
        if (!rstn) begin
            m_inreset = 1;
            m_active  = 0;
            m_load    = 0;
        end else begin
            m_inreset = 0;
            if (m_active) begin
                if (abort) begin
                    m_active = 0;
                    m_abort  = 1;
                end else begin
                    if (m_load && in_valid) begin
                        m_hs++;
                        if (m_hs == m_L) begin
                            m_load = 0;
                            m_lend = m_c;
                        end
                    end
                    m_c++;
                    if (!m_load && m_c > m_lend + m_L + 2*N + 1) m_active = 0;
                end
            end else if (start && !abort) begin
                if (len >= 1 && int'(len) <= DEPTH) begin
                    m_active = 1;
                    m_load   = 1;
                    m_L      = int'(len);
                    m_hs     = 0;
                    m_c      = 1;
                    rel_cyc  = 1;
                end else begin
                    m_err = 1;
                end
            end
        end
    endtask

    task automatic do_checks();
        logic [N-1:0] exp_r, exp_w;
        bit post;
        int s;
        post  = m_active && !m_load;
        exp_w = (m_active && m_load && in_valid) ? '1 : '0;
        exp_r = '0;
        if (post && m_c >= m_lend + 2) begin
            s = m_c - m_lend - 2;
            for (int i = 0; i < N; i++) exp_r[i] = (s >= i) && (s < i + m_L);
        end
        check_eq("busy",      64'(busy),      64'(m_active));
        check_eq("in_ready",  64'(in_ready),  64'(m_active && m_load));
        check_eq("row_w_en",  64'(row_w_en),  64'(exp_w));
        check_eq("col_w_en",  64'(col_w_en),  64'(exp_w));
        check_eq("row_r_en",  64'(row_r_en),  64'(exp_r));
        check_eq("col_r_en",  64'(col_r_en),  64'(exp_r));
        check_eq("pe_rstn",   64'(pe_rstn),
                 64'(!(m_inreset || m_abort || (post && m_c == m_lend + 1))));
        check_eq("done",      64'(done),      64'(post && m_c == m_lend + m_L + 2*N + 1));
        check_eq("err",       64'(err),       64'(m_err));
        check_eq("row_wdata", 64'(row_wdata), 64'(in_spikes));
        check_eq("col_wdata", 64'(col_wdata), 64'(in_weights));
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = rel_cyc;
        end
        if (err === 1'b1) err_cnt++;
        if (row_w_en[0] === 1'b1) wr_cnt++;
    endtask

    // One clock cycle: check the current cycle, account FIFO traffic, advance.
    task automatic step();
        #1;
        if (chk_en) do_checks();
        for (int i = 0; i < N; i++) begin
            if (!rstn) begin
                rocc[i] = 0;
                cocc[i] = 0;
            end else begin
                if (row_r_en[i] && rocc[i] == 0)     flow_err++;
                if (row_w_en[i] && rocc[i] == DEPTH) flow_err++;
                if (col_r_en[i] && cocc[i] == 0)     flow_err++;
                if (col_w_en[i] && cocc[i] == DEPTH) flow_err++;
                rocc[i] = rocc[i] + int'(row_w_en[i]) - int'(row_r_en[i]);
                cocc[i] = cocc[i] + int'(col_w_en[i]) - int'(col_r_en[i]);
            end
        end
        @(posedge clk);
        model_update();
        chk_en = 1;
        @(negedge clk);
    endtask

    task automatic set_data();
        in_spikes  = N'($urandom());
        in_weights = (N*DW)'({$urandom(), $urandom()});
    endtask

    // Issue one start and run until the model says the job has ended.
    task automatic run_job(input int L, input int gap_pct, input logic [31:0] gap_mask,
                           input int abort_at, input int rst_at, input bit poke,
                           output int dc);
        int d0;
        d0       = done_cnt;
        dc       = -1;
        rstn     = 1'b1;
        abort    = 1'b0;
        start    = 1'b1;
        len      = LW'(L);
        in_valid = 1'b1;
        set_data();
        step();
        start = 1'b0;
        for (int k = 1; k < 200; k++) begin
            if (!m_active) break;
            in_valid = ($urandom_range(99) >= gap_pct) && !(k < 32 && gap_mask[k]);
            set_data();
            abort = (k == abort_at);
            rstn  = !(k == rst_at);
            start = poke && ($urandom_range(3) == 0);
            len   = LW'($urandom());
            step();
        end
        check_eq("job_ends", 64'(busy), 64'(0));
        start    = 1'b0;
        abort    = 1'b0;
        rstn     = 1'b1;
        in_valid = 1'b0;
        if (done_cnt > d0) dc = done_cyc;
    endtask

    task automatic reset_cycle();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int dc, w0, d0, e0;
        for (int i = 0; i < N; i++) begin
            rocc[i] = 0;
            cocc[i] = 0;
        end
        rstn = 1'b0; start = 1'b0; len = '0; abort = 1'b0; in_valid = 1'b0;
        set_data();
        repeat (3) step();
        rstn = 1'b1;

        // Continuous len=4 job.
        w0 = wr_cnt;
        run_job(4, 0, '0, 0, 0, 0, dc);
        check_eq("t1_done_cycle", 64'(dc), 64'(15));
        check_eq("t1_writes", 64'(wr_cnt - w0), 64'(4));

        // len=4 with in_valid low on cycles 2 and 4.
        w0 = wr_cnt;
        run_job(4, 0, 32'b10100, 0, 0, 0, dc);
        check_eq("t2_done_cycle", 64'(dc), 64'(17));
        check_eq("t2_writes", 64'(wr_cnt - w0), 64'(4));

        // Illegal lengths.
        e0 = err_cnt;
        run_job(0, 0, '0, 0, 0, 0, dc);
        run_job(9, 0, '0, 0, 0, 0, dc);
        step();
        check_eq("t3_err_pulses", 64'(err_cnt - e0), 64'(2));

        // abort together with start in IDLE: start ignored, no err.
        e0 = err_cnt;
        start = 1'b1; len = 4'd3; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        step();
        check_eq("t3_abort_start_err", 64'(err_cnt - e0), 64'(0));
        check_eq("t3_abort_start_busy", 64'(busy), 64'(0));

        // abort on the second STREAM cycle, then reset and a len=2 job.
        d0 = done_cnt;
        run_job(4, 0, '0, 7, 0, 0, dc);
        check_eq("t4_abort_no_done", 64'(done_cnt - d0), 64'(0));
        reset_cycle();
        run_job(2, 0, '0, 0, 0, 0, dc);
        check_eq("t4_done_cycle", 64'(dc), 64'(11));

        // Reset during DRAIN, then start straight after release.
        d0 = done_cnt;
        run_job(3, 0, '0, 0, 11, 0, dc);
        check_eq("t5_reset_no_done", 64'(done_cnt - d0), 64'(0));
        run_job(3, 0, '0, 0, 0, 0, dc);
        check_eq("t5_done_cycle", 64'(dc), 64'(13));

        // Full-depth jobs back to back with stray starts while busy.
        run_job(8, 0, '0, 0, 0, 1, dc);
        check_eq("t6_done_cycle_a", 64'(dc), 64'(23));
        run_job(8, 0, '0, 0, 0, 1, dc);
        check_eq("t6_done_cycle_b", 64'(dc), 64'(23));
        check_eq("t6_fifo_empty", 64'(rocc[0] + rocc[N-1] + cocc[0] + cocc[N-1]), 64'(0));

        // Randomized jobs.
        for (int j = 0; j < 25; j++) begin
            int L, gp, ab, rs;
            L  = $urandom_range(0, 10);
            gp = $urandom_range(0, 40);
            ab = ($urandom_range(3) == 0) ? $urandom_range(1, 30) : 0;
            rs = (ab == 0 && $urandom_range(4) == 0) ? $urandom_range(1, 30) : 0;
            run_job(L, gp, '0, ab, rs, $urandom_range(1), dc);
            if (ab != 0 || rs != 0) reset_cycle();
        end

        step();
        check_eq("fifo_flow_errors", 64'(flow_err), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
